semaforo_ctrl: RTL
==================

SEMAFORO_CTRL -- requirements
Module: semaforo_ctrl

Interface
REQ-001 The parameter CLK_DIV SHALL default to 100000000 and set the number of clocks per one-second tick.
REQ-002 The parameter T_GREEN SHALL default to 25 and set the green duration in seconds (range 1..55).
REQ-003 The parameter T_YELLOW SHALL default to 4 and set the yellow duration in seconds (range 1..55).
REQ-004 The parameter T_ALLRED SHALL default to 2 and set the all-red clearance duration in seconds (range 1..55).
REQ-005 The parameter T_PED SHALL default to 5 and set the shortened green remainder applied on a pedestrian request (range 1..T_GREEN).
REQ-006 The port list SHALL be as follows: CLK100MHZ, input, 1 bit, the single clock.
REQ-007 RST_N, input, 1 bit, synchronous active-low reset.
REQ-008 PED_REQ, input, 1 bit, pedestrian request; a pulse of one or more cycles is sufficient.
REQ-009 LIGHT_NS, output, 3 bits {R,Y,G}, north-south lamps.
REQ-010 LIGHT_EW, output, 3 bits {R,Y,G}, east-west lamps.
REQ-011 COUNT, output, 6 bits, seconds remaining in the current phase, used to drive the two-digit 7-segment countdown.
REQ-012 SEC_TICK, output, 1 bit, one-cycle strobe once per second.
REQ-013 PED_WALK, output, 1 bit, pedestrian walk lamp.
REQ-014 STATE, output, 3 bits, current phase code for debug.

Function
REQ-015 The prescaler SHALL count 0..CLK_DIV-1, wrap to 0, and assert SEC_TICK for exactly the cycle in which its value equals CLK_DIV-1.
REQ-016 The FSM SHALL have six states with codes 0..5: AR1, NS_G, NS_Y, AR2, EW_G, EW_Y.
REQ-017 The transition cycle SHALL be AR1->NS_G->NS_Y->AR2->EW_G->EW_Y->AR1.
REQ-018 The lamps SHALL be decoded from state: NS_G NS=001/EW=100; NS_Y NS=010/EW=100; EW_G NS=100/EW=001; EW_Y NS=100/EW=010; AR1 and AR2 both 100.
REQ-019 In no state SHALL both directions show non-red simultaneously.
REQ-020 On entry to a state, COUNT SHALL load that state's duration: T_ALLRED, T_GREEN, or T_YELLOW.
REQ-021 On a SEC_TICK with COUNT>1, COUNT SHALL decrement by 1.
REQ-022 On a SEC_TICK with COUNT==1, the FSM SHALL advance to the next state and load the new duration in the same clock edge.
REQ-023 COUNT SHALL never read 0 after reset completes, and SHALL never exceed 55.
REQ-024 Phase latency SHALL be exactly duration×CLK_DIV clocks; state and lamp outputs SHALL change on the clock edge that ends the tick cycle.
REQ-025 A high PED_REQ sampled on any clock edge SHALL set the internal flag ped_pending.
REQ-026 ped_pending SHALL be cleared on the edge that enters EW_G.
REQ-027 If PED_REQ is high on the same edge that enters EW_G, the clear SHALL win; that request counts as served.
REQ-028 In NS_G, on a SEC_TICK with ped_pending=1 and COUNT>T_PED, COUNT SHALL load T_PED instead of decrementing.
REQ-029 In NS_G, on a SEC_TICK with ped_pending=1 and COUNT<=T_PED, the normal rules of REQ-021/REQ-022 SHALL apply.
REQ-030 PED_WALK SHALL be 1 only in EW_G (north-south crossing is served while north-south traffic is red).
REQ-031 All outputs SHALL be registered, except the lamp decode and STATE, which SHALL be direct from the state register.

Reset
REQ-032 When RST_N=0 is sampled at a clock edge, the block SHALL set prescaler=0, state=AR1, COUNT=T_ALLRED, ped_pending=0, SEC_TICK=0.
REQ-033 During reset, the outputs SHALL be LIGHT_NS=100, LIGHT_EW=100, PED_WALK=0, STATE=0.
REQ-034 Reset SHALL take priority over a simultaneous tick or PED_REQ.
REQ-035 Reset asserted mid-phase SHALL abandon the phase with no further transition.
REQ-036 The first tick after reset release SHALL occur CLK_DIV cycles after the first edge with RST_N=1.

Verification
Bench parameters for all scenarios: CLK_DIV=4, T_GREEN=6, T_YELLOW=2, T_ALLRED=1, T_PED=2.
REQ-037 Full cycle: release reset with PED_REQ=0 -> states 0,1,2,3,4,5,0 with dwells of 4,24,8,4,24,8 clocks; COUNT sequence in NS_G is 6,5,4,3,2,1.
REQ-038 Tick: run 40 clocks -> SEC_TICK high on exactly 10 isolated cycles, spaced 4 clocks apart.
REQ-039 Pedestrian shortening: pulse PED_REQ for 1 cycle while in NS_G with COUNT=5 -> next tick loads COUNT=2, then 1, then NS_Y; PED_WALK=1 throughout the following EW_G; ped_pending clears on EW_G entry.
REQ-040 Late pedestrian request: PED_REQ while in NS_G with COUNT=2 -> COUNT=1, then NS_Y; timing is unchanged.
REQ-041 Request coincident with serve: PED_REQ high on the EW_G entry edge -> ped_pending=0, and the next NS_G runs the full 6 seconds.
REQ-042 Reset mid-phase: assert RST_N=0 during EW_G with COUNT=3 for 1 cycle -> next state AR1, COUNT=1, lamps 100/100, PED_WALK=0, prescaler restarts from 0.

Source files
------------

// File: rtl/semaforo_ctrl.sv
// Two-way traffic light controller: six-phase cycle with a one-second prescaler,
// per-phase countdown and a pedestrian request that shortens the north-south green.
module semaforo_ctrl #(
  parameter int unsigned CLK_DIV  = 100000000,
  parameter int unsigned T_GREEN  = 25,
  parameter int unsigned T_YELLOW = 4,
  parameter int unsigned T_ALLRED = 2,
  parameter int unsigned T_PED    = 5
) (
  input  logic       CLK100MHZ,
  input  logic       RST_N,
  input  logic       PED_REQ,
  output logic [2:0] LIGHT_NS,
  output logic [2:0] LIGHT_EW,
  output logic [5:0] COUNT,
  output logic       SEC_TICK,
  output logic       PED_WALK,
  output logic [2:0] STATE
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMax = PW'(CLK_DIV - 1);

  localparam logic [2:0] LampRed = 3'b100;
  localparam logic [2:0] LampYel = 3'b010;
  localparam logic [2:0] LampGrn = 3'b001;

  typedef enum logic [2:0] {
    StAr1 = 3'd0,
    StNsG = 3'd1,
    StNsY = 3'd2,
    StAr2 = 3'd3,
    StEwG = 3'd4,
    StEwY = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    count_q, count_d;
  logic          ped_pending_q, ped_pending_d;
  logic          tick_q;
  logic          walk_q;

  function automatic state_e next_phase(input state_e s);
    case (s)
      StAr1:   next_phase = StNsG;
      StNsG:   next_phase = StNsY;
      StNsY:   next_phase = StAr2;
      StAr2:   next_phase = StEwG;
      StEwG:   next_phase = StEwY;
      default: next_phase = StAr1;
    endcase
  endfunction

  function automatic logic [5:0] phase_dur(input state_e s);
    case (s)
      StNsG, StEwG: phase_dur = 6'(T_GREEN);
      StNsY, StEwY: phase_dur = 6'(T_YELLOW);
      default:      phase_dur = 6'(T_ALLRED);
    endcase
  endfunction

  always_comb begin
    presc_d = (presc_q == PMax) ? '0 : presc_q + 1'b1;
    state_d = state_q;
    count_d = count_q;
    if (tick_q) begin
      if (count_q == 6'd1) begin
        state_d = next_phase(state_q);
        count_d = phase_dur(state_d);
      end else if (state_q == StNsG && ped_pending_q && count_q > 6'(T_PED)) begin
        count_d = 6'(T_PED);
      end else begin
        count_d = count_q - 6'd1;
      end
    end
    // Entering EW_G serves the request, even one arriving on that same edge.
    if (state_d == StEwG && state_q != StEwG) begin
      ped_pending_d = 1'b0;
    end else begin
      ped_pending_d = ped_pending_q | PED_REQ;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!RST_N) begin
      presc_q       <= '0;
      state_q       <= StAr1;
      count_q       <= 6'(T_ALLRED);
      ped_pending_q <= 1'b0;
      tick_q        <= 1'b0;
      walk_q        <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      state_q       <= state_d;
      count_q       <= count_d;
      ped_pending_q <= ped_pending_d;
      // Registered so the strobe is high exactly while the prescaler holds its top value.
      tick_q        <= (presc_d == PMax);
      walk_q        <= (state_d == StEwG);
    end
  end

  always_comb begin
    LIGHT_NS = LampRed;
    LIGHT_EW = LampRed;
    case (state_q)
      StNsG:   LIGHT_NS = LampGrn;
      StNsY:   LIGHT_NS = LampYel;
      StEwG:   LIGHT_EW = LampGrn;
      StEwY:   LIGHT_EW = LampYel;
      default: ;
    endcase
  end

  assign STATE    = state_q;
  assign COUNT    = count_q;
  assign SEC_TICK = tick_q;
  assign PED_WALK = walk_q;

endmodule
